top_module_prod_accum: RTL and testbench

TOP_MODULE_PROD_ACCUM -- requirements
Module: top_module_prod_accum

---
 rtl/top_module_accum_pkg.sv | 14 +
 rtl/top_module_prod_accum.sv | 119 +++++++++++
 tb/tb_top_module_prod_accum.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/top_module_accum_pkg.sv
// rtl/top_module_accum_pkg.sv - shared widths and FSM encoding for the product accumulator
package top_module_accum_pkg;

   localparam int DIN_WIDTH_DEF = 36;
   localparam int ACC_WIDTH_DEF = 48;
   localparam int CNT_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/top_module_prod_accum.sv
// rtl/top_module_prod_accum.sv - per-frame accumulator of unsigned multiplier products
// Sums each frame modulo 2^ACC_WIDTH with sticky overflow and a saturating beat count.
module top_module_prod_accum
   import top_module_accum_pkg::*;
#(
   parameter int DIN_WIDTH = DIN_WIDTH_DEF,
   parameter int ACC_WIDTH = ACC_WIDTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DIN_WIDTH-1:0] in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_overflow
);

   state_t                 state;
   state_t                 state_nxt;
   logic                   ready_en;
   logic [ACC_WIDTH-1:0]   acc;
   logic [CNT_WIDTH-1:0]   cnt;
   logic                   ovf;

   logic                   beat_acc;
   logic                   frame_end;
   logic                   release_hold;
   logic [ACC_WIDTH-1:0]   acc_base;
   logic [ACC_WIDTH:0]     sum_ext;
   logic [CNT_WIDTH-1:0]   cnt_nxt;
   logic                   ovf_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ready_en keeps in_ready low through reset and rises on the first clock after release
   always_comb begin
      state_nxt    = state;
      in_ready     = 1'b0;
      beat_acc     = 1'b0;
      frame_end    = 1'b0;
      release_hold = 1'b0;
      case (state)
         ST_IDLE, ST_ACCUM: begin
            in_ready  = ready_en;
            beat_acc  = in_valid && ready_en;
            frame_end = beat_acc && in_last;
            if (beat_acc) begin
               state_nxt = in_last ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_HOLD: begin
            release_hold = out_ready;
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // IDLE starts a fresh frame, so the running values are ignored there
   always_comb begin
      acc_base = (state == ST_IDLE) ? '0 : acc;
      sum_ext  = {1'b0, acc_base} + {{(ACC_WIDTH + 1 - DIN_WIDTH){1'b0}}, in_data};
      if (state == ST_IDLE) begin
         cnt_nxt = CNT_WIDTH'(1);
      end else if (&cnt) begin
         cnt_nxt = cnt;
      end else begin
         cnt_nxt = cnt + CNT_WIDTH'(1);
      end
      ovf_nxt = ((state == ST_IDLE) ? 1'b0 : ovf) | sum_ext[ACC_WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en     <= 1'b0;
         acc          <= '0;
         cnt          <= '0;
         ovf          <= 1'b0;
         out_valid    <= 1'b0;
         out_sum      <= '0;
         out_count    <= '0;
         out_overflow <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (beat_acc) begin
            acc <= sum_ext[ACC_WIDTH-1:0];
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
         end
         if (frame_end) begin
            out_valid    <= 1'b1;
            out_sum      <= sum_ext[ACC_WIDTH-1:0];
            out_count    <= cnt_nxt;
            out_overflow <= ovf_nxt;
         end else if (release_hold) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_top_module_prod_accum.sv
// tb/tb_top_module_prod_accum.sv - self-checking bench for top_module_prod_accum
module tb_top_module_prod_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [35:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [47:0] out_sum;
   logic [15:0] out_count;
   logic        out_overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   top_module_prod_accum dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_count    (out_count),
      .out_overflow (out_overflow)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] sat16(input int c);
      logic [31:0] v;
      v = c;
      return (c > 65535) ? 16'hFFFF : v[15:0];
   endfunction

   // Frame-level model: live once out of reset, true 64-bit sum per frame, one result held at a time
   logic        m_live;
   logic        m_hold;
   logic [63:0] m_sum;
   int          m_cnt;
   logic [47:0] e_sum;
   logic [15:0] e_cnt;
   logic        e_ovf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_live <= 1'b0;
         m_hold <= 1'b0;
         m_sum  <= '0;
         m_cnt  <= 0;
         e_sum  <= '0;
         e_cnt  <= '0;
         e_ovf  <= 1'b0;
      end else begin
         m_live <= 1'b1;
         if (m_hold) begin
            if (out_ready) m_hold <= 1'b0;
         end else if (m_live && in_valid) begin
            if (in_last) begin
               e_sum  <= 48'(m_sum + {28'd0, in_data});
               e_cnt  <= sat16(m_cnt + 1);
               e_ovf  <= (m_sum + {28'd0, in_data}) >= 64'h0001_0000_0000_0000;
               m_hold <= 1'b1;
               m_sum  <= '0;
               m_cnt  <= 0;
            end else begin
               m_sum <= m_sum + {28'd0, in_data};
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_sum", out_sum, 0);
         chk("rst_out_count", out_count, 0);
         chk("rst_out_overflow", out_overflow, 0);
      end else begin
         chk("in_ready", in_ready, m_live && !m_hold);
         chk("out_valid", out_valid, m_hold);
         if (m_hold) begin
            chk("out_sum", out_sum, e_sum);
            chk("out_count", out_count, e_cnt);
            chk("out_overflow", out_overflow, e_ovf);
         end
      end
   end

   task automatic send(input logic [35:0] d, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_result(input logic [47:0] es, input logic [15:0] ec, input logic eo);
      int n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("result_latency", n, 0);
      chk("lit_sum", out_sum, es);
      chk("lit_count", out_count, ec);
      chk("lit_overflow", out_overflow, eo);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      send(36'd3, 1'b0);
      send(36'd5, 1'b0);
      send(36'd7, 1'b1);
      wait_result(48'd15, 16'd3, 1'b0);

      send(36'hF_FFFF_FFFF, 1'b1);
      wait_result(48'h000F_FFFF_FFFF, 16'd1, 1'b0);

      for (int i = 0; i < 4097; i++) begin
         send(36'hF_FFFF_FFFF, i == 4096);
      end
      wait_result(48'h000F_FFFF_EFFF, 16'd4097, 1'b1);

      send(36'd2, 1'b0);
      send(36'd4, 1'b1);
      in_valid = 1'b1;
      in_data  = 36'h5A;
      in_last  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_sum", out_sum, 6);
         chk("bp_out_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      wait_result(48'h5A, 16'd1, 1'b0);

      send(36'd3, 1'b0);
      send(36'd4, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_sum", out_sum, 0);
      chk("mid_rst_out_count", out_count, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(36'd9, 1'b1);
      wait_result(48'd9, 16'd1, 1'b0);

      for (int i = 0; i < 4; i++) begin
         send(36'd1, i == 3);
         if (i < 3) begin
            in_data = 36'hABC;
            in_last = 1'b1;
            @(negedge clk);
            in_last = 1'b0;
         end
      end
      wait_result(48'd4, 16'd4, 1'b0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
